// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: LSU-facing data RAM responder with configurable read/write wait states.
// Optional out-of-range error reporting is enabled by defining RAM_OOR_ERR_EN.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module data_ram_ctrl #(
    parameter int AW      = 10,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsu_ram_valid,
    input  logic                lsu_ram_rd,
    input  logic                lsu_ram_wr,
    input  logic [`PC_SIZE-1:0] lsu_ram_addr,
    input  logic [`XLEN-1:0]    lsu_ram_wdata,
    output logic [`XLEN-1:0]    ram_lsu_rdata,
    output logic                ram_lsu_ready
`ifdef RAM_OOR_ERR_EN
    ,
    output logic                ram_lsu_err
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, wait_val;
    logic                accept, op_wr, oor_in, oor_q;
    logic                rd_is_wr, rd_oor;
    logic [AW-1:0]       addr_q, rd_addr;
    logic [`XLEN-1:0]    wdata_q;
    logic [`XLEN-1:0]    mem [0:(1<<AW)-1];

    assign accept   = (state == IDLE) && lsu_ram_valid && (lsu_ram_rd || lsu_ram_wr);
    assign wait_val = lsu_ram_wr ? 4'(WR_WAIT) : 4'(RD_WAIT);

`ifdef RAM_OOR_ERR_EN
    assign oor_in = |lsu_ram_addr[`PC_SIZE-1:AW];
`else
    logic unused_addr_hi;
    assign oor_in         = 1'b0;
    assign unused_addr_hi = ^lsu_ram_addr[`PC_SIZE-1:AW];
`endif

    // A zero-wait read enters RESP straight from IDLE, so it must use the live request, not the latch
    assign rd_is_wr = (state == IDLE) ? lsu_ram_wr : op_wr;
    assign rd_addr  = (state == IDLE) ? lsu_ram_addr[AW-1:0] : addr_q;
    assign rd_oor   = (state == IDLE) ? oor_in : oor_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (wait_val != 4'd0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: single ready pulse (and error flag) only in RESP
    always_comb begin
        ram_lsu_ready = (state == RESP);
`ifdef RAM_OOR_ERR_EN
        ram_lsu_err   = (state == RESP) && oor_q;
`endif
    end

    // Request latch, wait counter and registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            op_wr         <= 1'b0;
            oor_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            ram_lsu_rdata <= '0;
        end else begin
            if (accept) begin
                cnt     <= wait_val;
                op_wr   <= lsu_ram_wr;
                oor_q   <= oor_in;
                addr_q  <= lsu_ram_addr[AW-1:0];
                wdata_q <= lsu_ram_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state_nxt == RESP && !rd_is_wr)
                ram_lsu_rdata <= rd_oor ? '0 : mem[rd_addr];
        end
    end

    // Memory write commits on the edge leaving RESP; reset drops a pending write
    always_ff @(posedge clk) begin
        if (rst_n && state == RESP && op_wr && !oor_q)
            mem[addr_q] <= wdata_q;
    end

endmodule
